// File: rtl/euler_ram_arbiter_pkg.sv
// Shared definitions for the solver RAM arbiter: requester indices, FSM encoding
// and default RAM geometry.
package euler_ram_arbiter_pkg;

  localparam int REQ_HOST   = 0;
  localparam int REQ_INTERP = 1;
  localparam int REQ_SOLVER = 2;
  localparam int NUM_REQ    = 3;

  localparam int DEF_ADDRESS_WIDTH = 13;
  localparam int DEF_DATA_WIDTH    = 64;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Next requester index in the 0..2 rotation.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/euler_ram_arbiter_rr_pick3.sv
// Combinational round-robin picker over three requesters: returns the first set
// request at or after the start index, as one-hot and as an index.
module rr_pick3
  import euler_ram_arbiter_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_start,
  output logic [2:0] o_onehot,
  output logic [1:0] o_idx,
  output logic       o_valid
);

  logic [1:0] w_cand;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    // An out-of-range start (3) is treated as 0 so the index never leaves 0..2.
    w_cand   = (i_start == 2'd3) ? 2'd0 : i_start;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_valid && i_req[w_cand]) begin
        o_valid          = 1'b1;
        o_idx            = w_cand;
        o_onehot[w_cand] = 1'b1;
      end
      w_cand = next_idx(w_cand);
    end
  end

endmodule

// File: rtl/euler_ram_arbiter.sv
// Round-robin arbiter for the shared solver RAM: registered one-hot grant, locked
// bursts with a bounded hold time, and an owner mux onto the RAM ports.
module euler_ram_arbiter
  import euler_ram_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int MAX_HOLD      = 64
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [2:0]                 REQ,
  input  logic [2:0]                 LOCK,
  input  logic [3*ADDRESS_WIDTH-1:0] ADD_RD1_IN,
  input  logic [3*ADDRESS_WIDTH-1:0] ADD_RD2_IN,
  input  logic [3*ADDRESS_WIDTH-1:0] ADD_WR_IN,
  input  logic [3*DATA_WIDTH-1:0]    DATA_WR_IN,
  input  logic [2:0]                 WR_EN_IN,
  output logic [2:0]                 GNT,
  output logic [ADDRESS_WIDTH-1:0]   RAM_ADD_RD1,
  output logic [ADDRESS_WIDTH-1:0]   RAM_ADD_RD2,
  output logic [ADDRESS_WIDTH-1:0]   RAM_ADD_WR,
  output logic [DATA_WIDTH-1:0]      RAM_DATA_WR,
  output logic                       RAM_ENABLE_WR,
  output logic                       TIMEOUT,
  output logic                       ERROR,
  output arb_state_t                 DBG_STATE
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD - 1);

  arb_state_t    r_state, w_state_nxt;
  logic [2:0]    r_gnt, w_gnt_nxt;
  logic [1:0]    r_owner, w_owner_nxt;
  logic [1:0]    r_ptr, w_ptr_nxt;
  logic [HW-1:0] r_hold_cnt, w_hold_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic          r_error;

  logic [2:0]    w_others;
  logic          w_owner_req;
  logic          w_owner_lock;
  logic          w_handover;
  logic [2:0]    w_pick_req;
  logic [1:0]    w_pick_start;
  logic [2:0]    w_pick_onehot;
  logic [1:0]    w_pick_idx;
  logic          w_pick_valid;

  assign w_others     = REQ & ~r_gnt;
  assign w_owner_req  = |(REQ & r_gnt);
  assign w_owner_lock = |(LOCK & r_gnt);

  // From IDLE search all requests from PTR; while owning, search the others from OWNER+1.
  assign w_pick_req   = (r_state == OWN) ? w_others : REQ;
  assign w_pick_start = (r_state == OWN) ? next_idx(r_owner) : r_ptr;

  rr_pick3 u_pick (
    .i_req    (w_pick_req),
    .i_start  (w_pick_start),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_owner_nxt   = r_owner;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold_cnt;
    w_timeout_nxt = 1'b0;
    w_handover    = 1'b0;

    case (r_state)
      IDLE: begin
        w_hold_nxt = '0;
        w_handover = w_pick_valid;
      end
      OWN: begin
        if (!w_owner_req) begin
          if (w_pick_valid) begin
            w_handover = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_hold_nxt  = '0;
          end
        end else if (!w_pick_valid) begin
          w_hold_nxt = r_hold_cnt;
        end else if (!w_owner_lock) begin
          w_handover = 1'b1;
        end else if (r_hold_cnt == HOLD_LIMIT) begin
          w_handover    = 1'b1;
          w_timeout_nxt = 1'b1;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_hold_nxt  = '0;
      end
    endcase

    if (w_handover) begin
      w_state_nxt = OWN;
      w_gnt_nxt   = w_pick_onehot;
      w_owner_nxt = w_pick_idx;
      w_ptr_nxt   = next_idx(w_pick_idx);
      w_hold_nxt  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_owner    <= w_owner_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_timeout  <= w_timeout_nxt;
      r_error    <= r_error | w_timeout_nxt;
    end
  end

  // AND-OR mux keyed on the registered grant; everything reads zero with no owner.
  always_comb begin
    RAM_ADD_RD1 = '0;
    RAM_ADD_RD2 = '0;
    RAM_ADD_WR  = '0;
    RAM_DATA_WR = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gnt[i]) begin
        RAM_ADD_RD1 = RAM_ADD_RD1 | ADD_RD1_IN[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        RAM_ADD_RD2 = RAM_ADD_RD2 | ADD_RD2_IN[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        RAM_ADD_WR  = RAM_ADD_WR  | ADD_WR_IN[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        RAM_DATA_WR = RAM_DATA_WR | DATA_WR_IN[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign RAM_ENABLE_WR = |(WR_EN_IN & REQ & r_gnt);
  assign GNT           = r_gnt;
  assign TIMEOUT       = r_timeout;
  assign ERROR         = r_error;
  assign DBG_STATE     = r_state;

endmodule

// File: tb/tb_euler_ram_arbiter.sv
// Directed bench for euler_ram_arbiter: a per-cycle vector table plus hand-written
// burst and hold-timeout sequences.
module tb_euler_ram_arbiter;
  import euler_ram_arbiter_pkg::*;

  localparam int AW = 13;
  localparam int DW = 64;
  localparam int MH = 4;
  localparam int NV = 22;

  logic          CLK = 1'b0;
  logic          RST;
  logic [2:0]    req, lock, wr_en;
  logic [3*AW-1:0] add_rd1, add_rd2, add_wr;
  logic [3*DW-1:0] data_wr;
  logic [2:0]    gnt;
  logic [AW-1:0] ram_rd1, ram_rd2, ram_wr;
  logic [DW-1:0] ram_data;
  logic          ram_we, timeout, error;
  arb_state_t    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_q[$];

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [2:0] lock;
    logic [2:0] wr_en;
    logic [2:0] exp_gnt;
    logic       exp_we;
    logic       exp_to;
    logic       exp_err;
  } vec_t;

  vec_t vecs[NV];

  euler_ram_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MH)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .REQ           (req),
    .LOCK          (lock),
    .ADD_RD1_IN    (add_rd1),
    .ADD_RD2_IN    (add_rd2),
    .ADD_WR_IN     (add_wr),
    .DATA_WR_IN    (data_wr),
    .WR_EN_IN      (wr_en),
    .GNT           (gnt),
    .RAM_ADD_RD1   (ram_rd1),
    .RAM_ADD_RD2   (ram_rd2),
    .RAM_ADD_WR    (ram_wr),
    .RAM_DATA_WR   (ram_data),
    .RAM_ENABLE_WR (ram_we),
    .TIMEOUT       (timeout),
    .ERROR         (error),
    .DBG_STATE     (dbg_state)
  );

  // Clock and reset
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input logic [3*AW-1:0] bus, input logic [2:0] g);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) if (g[i]) r = bus[i*AW +: AW];
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [3*DW-1:0] bus, input logic [2:0] g);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) if (g[i]) r = bus[i*DW +: DW];
    return r;
  endfunction

  // Driver: one cycle of inputs, applied just after the rising edge.
  task automatic drive(input logic r, input logic [2:0] q, input logic [2:0] l, input logic [2:0] w);
    @(posedge CLK);
    #1;
    RST   = r;
    req   = q;
    lock  = l;
    wr_en = w;
    #1;
  endtask

  initial begin
    RST     = 1'b1;
    req     = '0;
    lock    = '0;
    wr_en   = '0;
    add_rd1 = {13'd102, 13'd101, 13'd100};
    add_rd2 = {13'd202, 13'd201, 13'd200};
    add_wr  = {13'd302, 13'd301, 13'd7};
    data_wr = {64'hC0DE_0000_0000_0002, 64'hB0B0_0000_0000_0001, 64'hA0A0_0000_0000_0000};

    //          rst   req     lock    wr_en   gnt     we    to    err
    vecs[0]  = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 3'b111, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 3'b111, 3'b000, 3'b111, 3'b001, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 3'b111, 3'b000, 3'b111, 3'b010, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'b111, 3'b000, 3'b111, 3'b100, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 3'b111, 3'b000, 3'b111, 3'b001, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3'b000, 3'b000, 3'b111, 3'b010, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 3'b010, 3'b010, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 3'b110, 3'b010, 3'b010, 3'b010, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 3'b100, 3'b000, 3'b010, 3'b010, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 3'b100, 3'b000, 3'b000, 3'b100, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b100, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 3'b101, 3'b001, 3'b100, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 3'b101, 3'b001, 3'b100, 3'b001, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 3'b001, 3'b001, 3'b001, 3'b001, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 3'b111, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 3'b111, 3'b000, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b100, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].lock, vecs[i].wr_en);
      check($sformatf("gnt[%0d]", i), 64'(gnt), 64'(vecs[i].exp_gnt));
      check($sformatf("we[%0d]", i), 64'(ram_we), 64'(vecs[i].exp_we));
      check($sformatf("rd1[%0d]", i), 64'(ram_rd1), 64'(exp_addr(add_rd1, vecs[i].exp_gnt)));
      check($sformatf("rd2[%0d]", i), 64'(ram_rd2), 64'(exp_addr(add_rd2, vecs[i].exp_gnt)));
      check($sformatf("wr_addr[%0d]", i), 64'(ram_wr), 64'(exp_addr(add_wr, vecs[i].exp_gnt)));
      check($sformatf("wr_data[%0d]", i), ram_data, exp_data(data_wr, vecs[i].exp_gnt));
      check($sformatf("timeout[%0d]", i), 64'(timeout), 64'(vecs[i].exp_to));
      check($sformatf("error[%0d]", i), 64'(error), 64'(vecs[i].exp_err));
      check($sformatf("state[%0d]", i), 64'(dbg_state),
            64'((vecs[i].exp_gnt != 3'b000) ? OWN : IDLE));
    end

    // Solver-only locked burst writing 5407..5416
    for (int k = 0; k < 10; k++) exp_q.push_back(AW'(5407 + k));
    add_wr[2*AW +: AW] = 13'd5407;
    drive(1'b0, 3'b100, 3'b100, 3'b100);
    check("burst_gnt_pre", 64'(gnt), 64'(3'b000));
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK);
      #1;
      add_wr[2*AW +: AW]  = AW'(5407 + k);
      data_wr[2*DW +: DW] = 64'hBEEF_0000_0000_0000 + 64'(k);
      #1;
      check($sformatf("burst_gnt[%0d]", k), 64'(gnt), 64'(3'b100));
      check($sformatf("burst_we[%0d]", k), 64'(ram_we), 64'(1'b1));
      check($sformatf("burst_addr[%0d]", k), 64'(ram_wr), 64'(exp_q.pop_front()));
      check($sformatf("burst_data[%0d]", k), ram_data, 64'hBEEF_0000_0000_0000 + 64'(k));
      check($sformatf("burst_to[%0d]", k), 64'(timeout), 64'(1'b0));
    end
    drive(1'b0, 3'b000, 3'b000, 3'b000);
    check("burst_last_gnt", 64'(gnt), 64'(3'b100));
    check("burst_last_we", 64'(ram_we), 64'(1'b0));
    drive(1'b0, 3'b000, 3'b000, 3'b000);
    check("burst_end_gnt", 64'(gnt), 64'(3'b000));

    // Locked solver with host contending: forced handover after MH contended cycles
    drive(1'b0, 3'b100, 3'b100, 3'b000);
    check("to_gnt_idle", 64'(gnt), 64'(3'b000));
    drive(1'b0, 3'b100, 3'b100, 3'b000);
    check("to_gnt_own", 64'(gnt), 64'(3'b100));
    for (int k = 0; k < MH; k++) begin
      drive(1'b0, 3'b101, 3'b100, 3'b000);
      check($sformatf("to_hold_gnt[%0d]", k), 64'(gnt), 64'(3'b100));
      check($sformatf("to_hold_pulse[%0d]", k), 64'(timeout), 64'(1'b0));
      check($sformatf("to_hold_err[%0d]", k), 64'(error), 64'(1'b0));
    end
    drive(1'b0, 3'b101, 3'b100, 3'b000);
    check("to_host_gnt", 64'(gnt), 64'(3'b001));
    check("to_pulse", 64'(timeout), 64'(1'b1));
    check("to_err_set", 64'(error), 64'(1'b1));
    drive(1'b0, 3'b000, 3'b000, 3'b000);
    check("to_solver_back", 64'(gnt), 64'(3'b100));
    check("to_pulse_once", 64'(timeout), 64'(1'b0));
    check("to_err_sticky", 64'(error), 64'(1'b1));
    drive(1'b0, 3'b000, 3'b000, 3'b000);
    check("to_idle_gnt", 64'(gnt), 64'(3'b000));
    check("to_err_idle", 64'(error), 64'(1'b1));
    drive(1'b1, 3'b000, 3'b000, 3'b000);
    check("to_err_before_rst", 64'(error), 64'(1'b1));
    drive(1'b0, 3'b000, 3'b000, 3'b000);
    check("to_err_cleared", 64'(error), 64'(1'b0));
    check("to_pulse_cleared", 64'(timeout), 64'(1'b0));
    check("to_gnt_cleared", 64'(gnt), 64'(3'b000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/euler_ram_arbiter.md
# euler_ram_arbiter

Arbitrates the shared solver RAM (two read ports, one write port) between three requesters: host loader, interpolator and Euler step controller. The block registers a one-hot grant and muxes the owner's addresses, write data and write enable onto the RAM ports. It sits between the requesters and the RAM instance in the solver top level. Read data is broadcast by the top level and is valid only to the current owner. Ownership rotates round-robin, locked bursts are supported, and a hold timeout bounds starvation.

## Interface
- ADDRESS_WIDTH, 13, RAM address width
- DATA_WIDTH, 64, RAM word width
- MAX_HOLD, 64, max consecutive cycles a locked owner may keep the grant while another requester waits
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- REQ  in  3  request per requester; bit0 host, bit1 interpolator, bit2 solver
- LOCK  in  3  owner wants to keep the grant across cycles (burst)
- ADD_RD1_IN, ADD_RD2_IN, ADD_WR_IN  in  3*ADDRESS_WIDTH  per-requester addresses; requester i in slice [i*AW +: AW]
- DATA_WR_IN  in  3*DATA_WIDTH  per-requester write data
- WR_EN_IN  in  3  per-requester write enable
- GNT  out  3  registered one-hot grant, or all-zero
- RAM_ADD_RD1, RAM_ADD_RD2, RAM_ADD_WR  out  ADDRESS_WIDTH  muxed addresses
- RAM_DATA_WR  out  DATA_WIDTH  muxed write data
- RAM_ENABLE_WR  out  1  muxed write enable
- TIMEOUT  out  1  one-cycle pulse on forced release
- ERROR  out  1  sticky; set by any TIMEOUT, cleared only by RST

## Operation
- States: IDLE (GNT=0) and OWN (GNT one-hot, owner index OWNER).
- Round-robin pointer PTR (2 bits, values 0..2). Search order is PTR, PTR+1, PTR+2 mod 3. PTR=0 at reset.
- IDLE: if any REQ is set, grant the first requester in search order at the next edge and go to OWN. Otherwise stay in IDLE.
- OWN, decided each edge:
  - REQ[OWNER]=0: release. If another requester is pending, hand over directly to the next in search order starting at OWNER+1; otherwise go to IDLE.
  - REQ[OWNER]=1, LOCK[OWNER]=0, another requester pending: hand over to the next requester after OWNER.
  - REQ[OWNER]=1 and no other requester pending: keep the grant.
  - REQ[OWNER]=1, LOCK[OWNER]=1: keep the grant unless HOLD_CNT has reached MAX_HOLD-1 with another requester pending. In that case force the handover, pulse TIMEOUT and set ERROR.
- On every grant change, PTR is set to new OWNER+1 mod 3.
- HOLD_CNT counts cycles in OWN during which another REQ is pending. It clears on any grant change and in IDLE, and it saturates.
- Mux (combinational from registered GNT):
  - RAM address and data outputs = owner's slices; all zero when GNT=0.
  - RAM_ENABLE_WR = WR_EN_IN[OWNER] & REQ[OWNER] & (GNT≠0). A write is never issued for a withdrawn request.
- WR_EN_IN from non-owners is ignored.

## Timing
- Reset values: GNT=0, RAM_* outputs 0, RAM_ENABLE_WR=0, TIMEOUT=0, ERROR=0, PTR=0, HOLD_CNT=0. RST mid-burst drops the grant at that edge; no write is issued in the following cycle.
- Request-to-grant latency is 1 edge from IDLE. Handover is back-to-back, with no idle cycle between owners.
- A requester drives its addresses in the same cycle it sees its GNT bit high. RAM read data is valid in that cycle (asynchronous read); the write commits at the end of that cycle.
- Simultaneous REQ from all three out of reset: grant order host, then interpolator, then solver, with each unlocked owner holding 1 cycle.
- When the owner drops REQ in the same cycle another requester raises REQ, the newcomer is granted at the next edge.
- Forced release: the locked owner sees its GNT bit low after exactly MAX_HOLD cycles of contention. It may re-request and is served in normal rotation.

## Structure
- Shared package: requester index constants (REQ_HOST=0, REQ_INTERP=1, REQ_SOLVER=2), state encoding (IDLE, OWN), and the default widths 13/64.
- One sub-module is natural: rr_pick3, a combinational round-robin picker taking a 3-bit request vector and a start index and returning a one-hot result plus a valid flag. It is used for both the IDLE and OWN decisions.

## Test plan
- Reset, then REQ=3'b111 with LOCK=0 held: GNT sequence 001, 010, 100, 001 on consecutive cycles; no idle gaps.
- Solver only, LOCK=1, 10-cycle burst writing addresses 5407..5416: GNT=100 held for 10 cycles; RAM_ENABLE_WR=1 each cycle with the correct address and data; TIMEOUT stays 0.
- Solver locked and host requesting, MAX_HOLD=4: host granted on the 5th cycle after contention starts; TIMEOUT pulses once; ERROR stays 1 until RST.
- Interpolator owner drops REQ while WR_EN_IN[1]=1: RAM_ENABLE_WR=0 that cycle; GNT goes to the pending solver at the next edge.
- RST asserted mid-burst (host owning, writing address 7): next cycle GNT=0 and RAM_ENABLE_WR=0; after release, rotation restarts from host.
- Non-owner WR_EN_IN[2]=1 while the host owns with WR_EN=0: RAM_ENABLE_WR stays 0 and RAM_ADD_WR equals the host's address.
